// File: rtl/rmt_pkg.sv
// Shared RMT pipeline constants: PHV container layout and derived PHV width.
// Imported by the match-action stages and by the PHV elastic buffer.
package rmt_pkg;

  // Container counts per width class and their bit widths.
  localparam int unsigned C48_NUM = 8;
  localparam int unsigned C32_NUM = 8;
  localparam int unsigned C16_NUM = 8;
  localparam int unsigned C48_W   = 48;
  localparam int unsigned C32_W   = 32;
  localparam int unsigned C16_W   = 16;

  // Metadata: five 20-bit fields plus a 256-bit opaque block.
  localparam int unsigned META_W  = 5 * 20 + 256;

  localparam int unsigned PHV_LEN = C48_NUM * C48_W + C32_NUM * C32_W
                                  + C16_NUM * C16_W + META_W;

  // Width of an occupancy counter able to hold the value 'depth'.
  function automatic int unsigned occ_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/phv_ebuf_ram.sv
// Simple dual-port PHV storage: one write port, one registered read port.
// Ports:
//   clk                       clock
//   wr_en / wr_addr / wr_data write port
//   rd_en / rd_addr           read request; rd_data updates on the next edge
//   rd_data                   registered read data (holds when rd_en=0)
// A read and a write to the same address on one edge return the old contents.
module phv_ebuf_ram #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/phv_elastic_buffer.sv
// Elastic PHV buffer between match-action stages. Captures every phv_in_valid
// pulse and replays PHVs downstream while stg_ready_in is high; stg_ready gives
// upstream early backpressure leaving SKID entries for in-flight PHVs.
// Ports:
//   axis_clk, aresetn        clock, async active-low reset
//   phv_in, phv_in_valid     upstream PHV and one-cycle push strobe
//   stg_ready                upstream may launch new PHVs (registered)
//   phv_out, phv_out_valid   downstream PHV and one-cycle qualifier
//   stg_ready_in             downstream ready
//   overflow                 sticky: a push was dropped while full
// Optional (macro PHV_EBUF_STATS_EN):
//   drop_cnt                 saturating count of dropped PHVs
//   max_occ                  occupancy high-water mark
module phv_elastic_buffer
  import rmt_pkg::*;
#(
  parameter int unsigned PHV_LEN = rmt_pkg::PHV_LEN,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned SKID    = 3
) (
  input  logic               axis_clk,
  input  logic               aresetn,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_in_valid,
  output logic               stg_ready,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_out_valid,
  input  logic               stg_ready_in,
  output logic               overflow
`ifdef PHV_EBUF_STATS_EN
  ,
  output logic [31:0]               drop_cnt,
  output logic [occ_w(DEPTH)-1:0]   max_occ
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] READY_LVL = CW'(DEPTH - SKID);

  logic [AW-1:0]      wp, rp;
  logic [CW-1:0]      cnt, cnt_next;
  logic               full, pop, push_ok, drop;
  logic               pop_q;
  logic [PHV_LEN-1:0] rd_data;

  // A push into a full buffer still succeeds when a pop frees the slot on the
  // same edge (wp==rp then; the RAM returns the old entry before overwrite).
  always_comb begin
    full     = (cnt == FULL_LVL);
    pop      = (cnt != '0) && stg_ready_in;
    push_ok  = phv_in_valid && (!full || pop);
    drop     = phv_in_valid && full && !pop;
    cnt_next = cnt;
    if (push_ok && !pop)      cnt_next = cnt + CW'(1);
    else if (!push_ok && pop) cnt_next = cnt - CW'(1);
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop)     rp <= rp + AW'(1);
      cnt <= cnt_next;
    end
  end

  // Pop reads the RAM on one edge; the following edge moves the data into
  // phv_out and raises phv_out_valid. Clearing pop_q on reset kills any read
  // already in flight.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      pop_q         <= 1'b0;
      phv_out_valid <= 1'b0;
      phv_out       <= '0;
      stg_ready     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      pop_q         <= pop;
      phv_out_valid <= pop_q;
      if (pop_q) phv_out <= rd_data;
      stg_ready     <= (cnt_next < READY_LVL);
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef PHV_EBUF_STATS_EN
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      drop_cnt <= '0;
      max_occ  <= '0;
    end else begin
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
      if (cnt_next > max_occ) max_occ <= cnt_next;
    end
  end
`endif

  phv_ebuf_ram #(
    .W     (PHV_LEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (axis_clk),
    .wr_en   (push_ok),
    .wr_addr (wp),
    .wr_data (phv_in),
    .rd_en   (pop),
    .rd_addr (rp),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_phv_elastic_buffer.sv
// Scoreboard bench for phv_elastic_buffer: a queue-based reference model
// predicts every output PHV and the edge it must appear on; a monitor checks
// outputs, stg_ready and overflow on every falling edge.
module tb_phv_elastic_buffer;
  import rmt_pkg::*;

  localparam int unsigned W     = rmt_pkg::PHV_LEN;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SKID  = 3;

  logic         axis_clk = 1'b0;
  logic         aresetn  = 1'b1;
  logic [W-1:0] phv_in   = '0;
  logic         phv_in_valid = 1'b0;
  logic         stg_ready;
  logic [W-1:0] phv_out;
  logic         phv_out_valid;
  logic         stg_ready_in = 1'b0;
  logic         overflow;
`ifdef PHV_EBUF_STATS_EN
  logic [31:0]             drop_cnt;
  logic [occ_w(DEPTH)-1:0] max_occ;
`endif

  always #5 axis_clk = ~axis_clk;

  phv_elastic_buffer #(
    .PHV_LEN (W),
    .DEPTH   (DEPTH),
    .SKID    (SKID)
  ) dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .phv_in        (phv_in),
    .phv_in_valid  (phv_in_valid),
    .stg_ready     (stg_ready),
    .phv_out       (phv_out),
    .phv_out_valid (phv_out_valid),
    .stg_ready_in  (stg_ready_in),
    .overflow      (overflow)
`ifdef PHV_EBUF_STATS_EN
    ,
    .drop_cnt      (drop_cnt),
    .max_occ       (max_occ)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    int unsigned  at_edge;
  } exp_t;

  logic [W-1:0] model_q[$];
  exp_t         exp_q[$];
  int unsigned  cyc = 0;
  int unsigned  n_chk = 0;
  int unsigned  n_pass = 0;
  bit           exp_ready = 1'b0;
  bit           exp_ovf = 1'b0;
  int unsigned  exp_drops = 0;
  int unsigned  exp_max = 0;

  task automatic chk(input string name, input bit ok,
                     input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [W-1:0] rand_phv();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // One clock of stimulus. The model is a plain bounded FIFO: an item leaves
  // when the buffer held something before the edge and downstream is ready,
  // an item enters if there is room or one is leaving, else it is dropped.
  // A departing item must appear on phv_out one edge after it departs.
  task automatic step(input bit v, input logic [W-1:0] d, input bit r);
    bit   pop, acc;
    exp_t e;
    phv_in_valid = v;
    phv_in       = d;
    stg_ready_in = r;
    pop = (model_q.size() != 0) && r;
    acc = v && ((model_q.size() < DEPTH) || pop);
    @(posedge axis_clk);
    cyc++;
    if (pop) begin
      e.data    = model_q.pop_front();
      e.at_edge = cyc + 1;
      exp_q.push_back(e);
    end
    if (acc) model_q.push_back(d);
    else if (v) begin
      exp_ovf = 1'b1;
      exp_drops++;
    end
    if (model_q.size() > exp_max) exp_max = model_q.size();
    exp_ready = (model_q.size() < DEPTH - SKID);
    @(negedge axis_clk);
  endtask

  task automatic idle(input int unsigned n, input bit r);
    repeat (n) step(1'b0, '0, r);
  endtask

  task automatic do_reset();
    #2 aresetn = 1'b0;
    model_q.delete();
    exp_q.delete();
    exp_ready = 1'b0;
    exp_ovf   = 1'b0;
    exp_drops = 0;
    exp_max   = 0;
    #1;
    chk("rst_phv_out", phv_out === '0, phv_out[63:0], 64'd0);
    chk("rst_valid", phv_out_valid === 1'b0, phv_out_valid, 0);
    chk("rst_stg_ready", stg_ready === 1'b0, stg_ready, 0);
    chk("rst_overflow", overflow === 1'b0, overflow, 0);
    repeat (2) @(negedge axis_clk);
    #1 aresetn = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge axis_clk);
      chk("stg_ready", stg_ready === exp_ready, stg_ready, exp_ready);
      chk("overflow", overflow === exp_ovf, overflow, exp_ovf);
      if (phv_out_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 1'b0, 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("phv_data", phv_out === e.data, phv_out[63:0], e.data[63:0]);
          chk("latency", cyc == e.at_edge, cyc, e.at_edge);
        end
      end else if (exp_q.size() != 0 && exp_q[0].at_edge <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_valid", 1'b0, 0, e.at_edge);
      end
    end
  endtask

  task automatic stimulus();
    // Reset release: stg_ready rises on the first edge.
    do_reset();
    chk("ready_before_edge", stg_ready === 1'b0, stg_ready, 0);
    idle(1, 1'b1);
    chk("ready_after_edge", stg_ready === 1'b1, stg_ready, 1);

    // Single PHV latency.
    step(1'b1, rand_phv(), 1'b1);
    idle(4, 1'b1);

    // 20 back-to-back PHVs.
    for (int i = 0; i < 20; i++) step(1'b1, W'(i), 1'b1);
    idle(4, 1'b1);
    chk("b2b_overflow", overflow === 1'b0, overflow, 0);

    // Backpressure: stg_ready drops after the 5th push.
    for (int i = 0; i < 5; i++) step(1'b1, W'(100 + i), 1'b0);
    chk("bp_ready_low", stg_ready === 1'b0, stg_ready, 0);
    idle(2, 1'b0);
    idle(8, 1'b1);

    // Overrun: 10 pushes into a stalled buffer, last two dropped.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, W'(200 + i), 1'b0);
    chk("ovf_set", overflow === 1'b1, overflow, 1);
`ifdef PHV_EBUF_STATS_EN
    chk("drop_cnt", drop_cnt == 32'd2, drop_cnt, 2);
    chk("max_occ", max_occ == DEPTH, max_occ, DEPTH);
`endif
    idle(12, 1'b1);

    // Full buffer, simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, W'(300 + i), 1'b0);
    step(1'b1, W'(399), 1'b1);
    chk("full_pushpop_no_drop", overflow === 1'b0, overflow, 0);
    idle(12, 1'b1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_phv(), $urandom_range(0, 2) != 0);
    idle(12, 1'b1);
`ifdef PHV_EBUF_STATS_EN
    chk("rand_drop_cnt", drop_cnt == exp_drops, drop_cnt, exp_drops);
    chk("rand_max_occ", max_occ == exp_max, max_occ, exp_max);
`endif

    // Reset with entries queued: nothing emerges, buffer restarts empty.
    for (int i = 0; i < 4; i++) step(1'b1, W'(500 + i), 1'b0);
    idle(1, 1'b1);
    do_reset();
    idle(10, 1'b1);
    step(1'b1, W'(777), 1'b1);
    idle(4, 1'b1);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    chk("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 0);
    chk("model_empty", model_q.size() == 0, model_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
